axi_refill_arbiter: RTL

Sits between the MMU/cache layer and the CPU's AXI read channels (AR/R). Arbitrates instruction-cache line refills and data-side reads (cached line refills or uncached single words) onto one AXI read port. Tracks one outstanding burst at a time and steers returning beats to the requester. Fixed priority: data before instruction.

---
 rtl/axi_refill_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/axi_refill_arbiter.sv
// Read-side AXI arbiter: serialises I-cache line refills and D-side reads onto one AR/R port,
// one outstanding burst at a time, data side has priority.
module axi_refill_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int OFF_W      = 5
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_grant,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_uncached,
    output logic        d_grant,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        rd_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [2:0] {IDLE, AR_I, AR_D, R_I, R_D} state_t;

    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [7:0]  BURST_LEN = 8'(LINE_WORDS - 1);

    state_t      state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [3:0]  arid_q, arid_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        i_grant_q, i_grant_d;
    logic        d_grant_q, d_grant_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        beat_s;
    logic        unused_ok_s;

    assign beat_s = rvalid & rready_q;

    // Next-state and next-register computation for the arbitration FSM
    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arid_d    = arid_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        i_grant_d = 1'b0;
        d_grant_d = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d   = AR_D;
                    arvalid_d = 1'b1;
                    arid_d    = 4'd1;
                    if (d_uncached) begin
                        araddr_d = d_addr;
                        arlen_d  = 8'd0;
                    end else begin
                        araddr_d = d_addr & LINE_MASK;
                        arlen_d  = BURST_LEN;
                    end
                end else if (i_req) begin
                    state_d   = AR_I;
                    arvalid_d = 1'b1;
                    arid_d    = 4'd0;
                    araddr_d  = i_addr & LINE_MASK;
                    arlen_d   = BURST_LEN;
                end else begin
                    state_d = IDLE;
                end
            end
            AR_I, AR_D: begin
                if (arready) begin
                    state_d   = (state_q == AR_D) ? R_D : R_I;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = 5'd0;
                    i_grant_d = (state_q == AR_I);
                    d_grant_d = (state_q == AR_D);
                end else begin
                    state_d = state_q;
                end
            end
            R_I, R_D: begin
                // rlast alone closes the burst; the count is only kept for observation
                if (beat_s) begin
                    cnt_d = cnt_q + 5'd1;
                    if (rlast) begin
                        state_d  = IDLE;
                        rready_d = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d   = IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    // State and registered AXI/grant outputs with synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            araddr_q  <= 32'd0;
            arlen_q   <= 8'd0;
            arid_q    <= 4'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            i_grant_q <= 1'b0;
            d_grant_q <= 1'b0;
            cnt_q     <= 5'd0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arid_q    <= arid_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            i_grant_q <= i_grant_d;
            d_grant_q <= d_grant_d;
            cnt_q     <= cnt_d;
        end
    end

    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arid    = arid_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign i_grant = i_grant_q;
    assign d_grant = d_grant_q;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign i_rvalid = beat_s & (state_q == R_I);
    assign d_rvalid = beat_s & (state_q == R_D);
    assign i_rlast  = i_rvalid & rlast;
    assign d_rlast  = d_rvalid & rlast;
    assign i_rdata  = rdata;
    assign d_rdata  = rdata;
    assign rd_err   = beat_s & (rresp != 2'b00);

    assign unused_ok_s = ^{rid, cnt_q};

endmodule
